// File: rtl/tick_sched.sv
// tick_sched: one shared prescaler feeding NCH reconfigurable tick/clock channels.
// Channel settings change only at a wrap, or immediately when the channel is idle.
// Optional build macro TICK_SCHED_CFG_ERR_EN adds the cfg_err output.
module tick_sched #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned PRE       = 50,
    parameter int unsigned PRE_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]       cfg_div,
    input  logic                   cfg_en,
    output logic                   cfg_done,
`ifdef TICK_SCHED_CFG_ERR_EN
    output logic                   cfg_err,
`endif
    output logic                   base_tick,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         clk_out
);

    localparam int unsigned CH_W = $clog2(NCH);
    localparam logic [PRE_WIDTH-1:0] PRE_LAST = PRE_WIDTH'(PRE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [PRE_WIDTH-1:0] pre_cnt;
    logic [WIDTH-1:0]     cnt [NCH];
    logic [WIDTH-1:0]     div [NCH];
    logic [NCH-1:0]       en;
    logic [CH_W-1:0]      pend_ch;
    logic [WIDTH-1:0]     pend_div;
    logic                 pend_en;
    logic [WIDTH-1:0]     div_last_c [NCH];
    logic [NCH-1:0]       wrap_c;
    logic [NCH-1:0]       pend_sel_c;
    logic                 pend_hit_c;
    logic [NCH-1:0]       apply_c;
    logic                 accept_c;

    // Base tick is decoded directly from the prescaler register, so PRE=1 strobes every cycle.
    assign base_tick = (pre_cnt == PRE_LAST);
    assign accept_c  = cfg_valid && cfg_ready;

    // Prescaler counting 0..PRE-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (base_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_WIDTH'(1);
        end
    end

    // Wrap detection per channel; a divisor of 0 behaves as 1.
    always_comb begin
        wrap_c = '0;
        for (int c = 0; c < NCH; c++) begin
            div_last_c[c] = (div[c] == '0) ? '0 : div[c] - WIDTH'(1);
            wrap_c[c]     = base_tick && en[c] && (cnt[c] == div_last_c[c]);
        end
    end

    // Config FSM next state and the apply strobe for the targeted channel.
    always_comb begin
        state_next = state;
        apply_c    = '0;
        pend_sel_c = '0;
        for (int c = 0; c < NCH; c++) begin
            if (pend_ch == CH_W'(c)) begin
                pend_sel_c[c] = 1'b1;
            end
        end
        pend_hit_c = |pend_sel_c;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!pend_hit_c) begin
                    state_next = ST_DONE;
                end else if ((|(pend_sel_c & ~en)) || (|(pend_sel_c & wrap_c))) begin
                    apply_c    = pend_sel_c;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b1;
            cfg_done  <= 1'b0;
        end else begin
            state     <= state_next;
            cfg_ready <= (state_next == ST_IDLE);
            cfg_done  <= (state_next == ST_DONE);
        end
    end

    // Pending request capture on handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_ch  <= '0;
            pend_div <= '0;
            pend_en  <= 1'b0;
        end else if (accept_c) begin
            pend_ch  <= cfg_ch;
            pend_div <= cfg_div;
            pend_en  <= cfg_en;
        end
    end

`ifdef TICK_SCHED_CFG_ERR_EN
    logic pend_err;
    logic cfg_hit_c;

    // Request channel range check at accept time.
    always_comb begin
        cfg_hit_c = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (cfg_ch == CH_W'(c)) begin
                cfg_hit_c = 1'b1;
            end
        end
    end

    // Error flag latched with the request and reported alongside cfg_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_err <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            if (accept_c) begin
                pend_err <= !cfg_hit_c || (cfg_en && (cfg_div == '0));
            end
            cfg_err <= (state_next == ST_DONE) && pend_err;
        end
    end
`endif

    // Channel counters, tick strobes and square waves; apply overrides the wrap's counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick    <= '0;
            clk_out <= '0;
            en      <= '0;
            for (int c = 0; c < NCH; c++) begin
                cnt[c] <= '0;
                div[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                tick[c] <= wrap_c[c];
                if (wrap_c[c]) begin
                    cnt[c]     <= '0;
                    clk_out[c] <= ~clk_out[c];
                end else if (base_tick && en[c]) begin
                    cnt[c] <= cnt[c] + WIDTH'(1);
                end
                if (apply_c[c]) begin
                    div[c] <= pend_div;
                    en[c]  <= pend_en;
                    cnt[c] <= '0;
                    if (!pend_en) begin
                        clk_out[c] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed vectors and multi-cycle sequences for tick_sched (PRE=4, NCH=3, WIDTH=8).
module tb_tick_sched;

    localparam int unsigned NCH       = 3;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned PRE       = 4;
    localparam int unsigned PRE_WIDTH = 3;
    localparam int          BUDGET    = 200;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [1:0]       cfg_ch = '0;
    logic [WIDTH-1:0] cfg_div = '0;
    logic             cfg_en = 1'b0;
    logic             cfg_done;
`ifdef TICK_SCHED_CFG_ERR_EN
    logic             cfg_err;
`endif
    logic             base_tick;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   clk_out;

    tick_sched #(
        .NCH(NCH), .WIDTH(WIDTH), .PRE(PRE), .PRE_WIDTH(PRE_WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_en(cfg_en),
        .cfg_done(cfg_done),
`ifdef TICK_SCHED_CFG_ERR_EN
        .cfg_err(cfg_err),
`endif
        .base_tick(base_tick),
        .tick(tick),
        .clk_out(clk_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] ch;
        logic [7:0] dv;
        logic       en;
        logic       bt;
        logic [2:0] tk;
        logic [2:0] co;
        logic       rdy;
        logic       dn;
    } vec_t;

    vec_t vecs [26];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int tick_cnt [NCH];
    int last_t   [NCH];
    int prev_t   [NCH];
    int first_t  [NCH];
    int min_per  [NCH];
    int max_per  [NCH];

    function automatic vec_t mk(input logic v, input logic [1:0] ch, input logic [7:0] dv,
                                input logic en, input logic bt, input logic [2:0] tk,
                                input logic [2:0] co, input logic rdy, input logic dn);
        vec_t r;
        r.v = v; r.ch = ch; r.dv = dv; r.en = en;
        r.bt = bt; r.tk = tk; r.co = co; r.rdy = rdy; r.dn = dn;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Advance one clock, sample after the edge and update tick statistics.
    task automatic step();
        int per;
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            if (tick[c]) begin
                if (tick_cnt[c] == 0) begin
                    first_t[c] = cyc;
                end else begin
                    per = cyc - last_t[c];
                    if (per < min_per[c]) min_per[c] = per;
                    if (per > max_per[c]) max_per[c] = per;
                end
                prev_t[c] = last_t[c];
                last_t[c] = cyc;
                tick_cnt[c]++;
            end
        end
        if (cfg_done) done_cnt++;
    endtask

    task automatic run_until(input int t);
        while (cyc < t) step();
    endtask

    // Issue one request; noise drives junk requests while the FSM is busy.
    task automatic cfg_send(input int ch, input int dv, input bit en, input bit noise,
                            output int acc, output int dn, output bit err);
        int budget;
        budget = 0;
        err = 1'b0;
        while (!cfg_ready && budget < BUDGET) begin
            step();
            budget++;
        end
        if (!cfg_ready) check("ready_timeout", int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = 8'(dv);
        cfg_en    = en;
        acc       = cyc;
        step();
        cfg_valid = 1'b0;
        budget = 0;
        while (!cfg_done && budget < BUDGET) begin
            if (noise) begin
                cfg_valid = 1'b1;
                cfg_ch    = 2'd2;
                cfg_div   = 8'd1;
                cfg_en    = 1'b1;
            end
            step();
            budget++;
        end
        cfg_valid = 1'b0;
        if (!cfg_done) check("done_timeout", int'(cfg_done), 1);
        dn = cyc;
`ifdef TICK_SCHED_CFG_ERR_EN
        err = cfg_err;
`endif
    endtask

    initial begin
        int acc, dn, before_done, before_ticks, after_ticks;
        bit err;

        for (int c = 0; c < NCH; c++) begin
            tick_cnt[c] = 0; last_t[c] = 0; prev_t[c] = 0; first_t[c] = 0;
            min_per[c] = 1000000; max_per[c] = 0;
        end

        //               v  ch dv en  bt tk co rdy dn
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[12] = mk(1, 0, 3, 1, 0, 0, 0, 1, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[15] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[19] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[23] = mk(0, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 1, 1, 1, 0);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);

        // Values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_done", int'(cfg_done), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_clk_out", int'(clk_out), 0);
        reset = 1'b0;
        cyc = 0;

        // Prescaler phase and first configuration of ch0 (div=3) from idle.
        for (int i = 0; i < 26; i++) begin
            cfg_valid = vecs[i].v;
            cfg_ch    = vecs[i].ch;
            cfg_div   = vecs[i].dv;
            cfg_en    = vecs[i].en;
            check($sformatf("vec%0d_base_tick", i), int'(base_tick), int'(vecs[i].bt));
            check($sformatf("vec%0d_tick", i), int'(tick), int'(vecs[i].tk));
            check($sformatf("vec%0d_clk_out", i), int'(clk_out), int'(vecs[i].co));
            check($sformatf("vec%0d_ready", i), int'(cfg_ready), int'(vecs[i].rdy));
            check($sformatf("vec%0d_done", i), int'(cfg_done), int'(vecs[i].dn));
            step();
        end
        cfg_valid = 1'b0;

        // ch0 steady state at div=3: tick every 12 clks, clk_out toggling.
        run_until(37);
        check("ch0_second_tick", last_t[0], 36);
        check("ch0_period_div3", last_t[0] - prev_t[0], 12);
        check("ch0_clk_out_low", int'(clk_out[0]), 0);

        // ch1 enable with div=0: one tick per base tick.
        cfg_send(1, 0, 1'b1, 1'b0, acc, dn, err);
        check("ch1_en_done_cycle", dn, 39);
        run_until(53);
        check("ch1_first_tick", first_t[1], 40);
        check("ch1_tick_count", tick_cnt[1], 4);
        check("ch1_min_period", min_per[1], 4);
        check("ch1_max_period", max_per[1], 4);

        // ch0 div 3 -> 5 while running; busy-time requests must be ignored.
        cfg_send(0, 5, 1'b1, 1'b1, acc, dn, err);
        check("ch0_redef_done_cycle", dn, 60);
        check("ch0_last_div3_tick", last_t[0], 60);
        check("ch0_last_div3_period", last_t[0] - prev_t[0], 12);
        run_until(81);
        check("ch0_div5_tick", last_t[0], 80);
        check("ch0_div5_period", last_t[0] - prev_t[0], 20);
        check("ch0_clk_out_high", int'(clk_out[0]), 1);
        check("ch1_undisturbed_min", min_per[1], 4);
        check("ch1_undisturbed_max", max_per[1], 4);
        check("ch1_count_80", tick_cnt[1], 11);
        check("ch2_noise_ignored", tick_cnt[2], 0);

        // Disable ch1 while running: final wrap tick, then silence.
        cfg_send(1, 0, 1'b0, 1'b0, acc, dn, err);
        check("ch1_dis_done_cycle", dn, 84);
        check("ch1_final_tick", last_t[1], 84);
        run_until(110);
        check("ch1_no_more_ticks", tick_cnt[1], 12);
        check("ch1_clk_out_zero", int'(clk_out[1]), 0);
        check("ch0_tick_100", last_t[0], 100);
        check("ch0_count_100", tick_cnt[0], 6);

        // Out-of-range channel: accepted, completes, nothing changes.
        before_ticks = tick_cnt[1] + tick_cnt[2];
        cfg_send(3, 4, 1'b1, 1'b0, acc, dn, err);
        check("bad_ch_latency", dn - acc, 2);
`ifdef TICK_SCHED_CFG_ERR_EN
        check("err_bad_ch", int'(err), 1);
`endif
        run_until(dn + 40);
        check("bad_ch_no_change", tick_cnt[1] + tick_cnt[2], before_ticks);

`ifdef TICK_SCHED_CFG_ERR_EN
        cfg_send(2, 0, 1'b0, 1'b0, acc, dn, err);
        check("err_dis_div0", int'(err), 0);
        cfg_send(2, 0, 1'b1, 1'b0, acc, dn, err);
        check("err_en_div0", int'(err), 1);
        cfg_send(2, 3, 1'b0, 1'b0, acc, dn, err);
        check("err_clean", int'(err), 0);
`endif

        // Reset asserted while a request waits for ch0's wrap.
        step();
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 8'd2;
        cfg_en    = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("wait_ready_low", int'(cfg_ready), 0);
        before_done  = done_cnt;
        before_ticks = tick_cnt[0] + tick_cnt[1] + tick_cnt[2];
        reset = 1'b1;
        #1;
        check("midrst_ready", int'(cfg_ready), 1);
        check("midrst_done", int'(cfg_done), 0);
        check("midrst_tick", int'(tick), 0);
        check("midrst_clk_out", int'(clk_out), 0);
        check("midrst_base_tick", int'(base_tick), 0);
        step();
        step();
        reset = 1'b0;
        check("rel_base_tick_c0", int'(base_tick), 0);
        step();
        step();
        step();
        check("rel_base_tick_c3", int'(base_tick), 1);
        repeat (40) step();
        after_ticks = tick_cnt[0] + tick_cnt[1] + tick_cnt[2];
        check("midrst_no_done", done_cnt, before_done);
        check("midrst_no_ticks", after_ticks, before_ticks);
        check("midrst_ready_idle", int'(cfg_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
